// File: rtl/instruction_sequencer.sv
// Fetch/issue sequencer: walks a loadable program memory and strobes
// each word into the processor with setup, execute and gap phases.
module instruction_sequencer #(
  parameter int         DEPTH       = 16,
  parameter int         AW          = 4,
  parameter int         SETUP_CYC   = 1,
  parameter int         EXEC_CYC    = 2,
  parameter int         GAP_CYC     = 2,
  parameter logic [2:0] HALT_OPCODE = 3'b111
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [10:0]   load_data,
  input  logic          start,
  input  logic          abort,
  output logic [10:0]   instruction,
  output logic          execute_next,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  localparam int M1   = (SETUP_CYC > EXEC_CYC) ? SETUP_CYC : EXEC_CYC;
  localparam int MAXC = (M1 > GAP_CYC) ? M1 : GAP_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EXEC_LAST  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [AW-1:0] LAST_PC    = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_EXEC, S_GAP, S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [10:0]   instr_q, instr_d;
  logic          exec_q, exec_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [10:0]   mem [DEPTH];
  logic          wr_ok;
  logic          wr_en;
  logic [10:0]   word0;
  logic [AW-1:0] pc_nx;

  assign wr_ok = (state_q == S_IDLE) || (state_q == S_HALT);
  assign wr_en = wr_ok && load_en;
  assign pc_nx = pc_q + AW'(1);

  // a same-cycle write to address 0 must be seen by the start fetch
  assign word0 = (wr_en && load_addr == '0) ? load_data : mem[0];

  always_ff @(posedge clk) begin
    if (wr_en) mem[load_addr] <= load_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    pc_d    = pc_q;
    instr_d = instr_q;
    exec_d  = exec_q;
    if (abort && state_q != S_IDLE) begin
      state_d = S_HALT;
      exec_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_HALT: begin
          cnt_d = '0;
          if (start) begin
            state_d = S_SETUP;
            pc_d    = '0;
            instr_d = word0;
          end
        end
        S_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            state_d = S_EXEC;
            exec_d  = 1'b1;
            cnt_d   = '0;
          end
        end
        S_EXEC: begin
          if (cnt_q == EXEC_LAST) begin
            state_d = S_GAP;
            exec_d  = 1'b0;
            cnt_d   = '0;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            if (instr_q[10:8] == HALT_OPCODE ||
                pc_q == LAST_PC) begin
              state_d = S_HALT;
            end else begin
              state_d = S_SETUP;
              pc_d    = pc_nx;
              instr_d = mem[pc_nx];
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          exec_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == S_SETUP) ||
             (state_d == S_EXEC) ||
             (state_d == S_GAP);
    done_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      exec_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      exec_q  <= exec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign instruction  = instr_q;
  assign execute_next = exec_q;
  assign pc           = pc_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: builds the expected issue timeline
// from the program image and compares every output cycle by cycle.
module tb_instruction_sequencer;

  localparam int SETUP = 1;
  localparam int EXEC  = 2;
  localparam int GAP   = 2;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [10:0] load_data;
  logic        start;
  logic        abort;
  logic [10:0] instruction;
  logic        execute_next;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  instruction_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .start        (start),
    .abort        (abort),
    .instruction  (instruction),
    .execute_next (execute_next),
    .pc           (pc),
    .busy         (busy),
    .done         (done)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] mdl [DEPTH];
  logic [17:0] obs_v;

  assign obs_v = {busy, done, execute_next, pc, instruction};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [10:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en = 1'b0;
    mdl[a]  = d;
  endtask

  // abort_at / rst_at: sample index after which abort or reset hits (-1 = none)
  task automatic run(input string tag, input int abort_at,
                     input int rst_at, input bit noise,
                     input bit wt, input logic [10:0] wtd);
    logic [17:0] q[$];
    logic [17:0] last;
    logic [10:0] w;
    int idx;
    if (wt) mdl[0] = wtd;
    idx = 0;
    forever begin
      w = mdl[idx];
      repeat (SETUP) q.push_back({3'b100, 4'(idx), w});
      repeat (EXEC)  q.push_back({3'b101, 4'(idx), w});
      repeat (GAP)   q.push_back({3'b100, 4'(idx), w});
      if (w[10:8] == 3'b111 || idx == DEPTH - 1) break;
      idx++;
    end
    if (abort_at >= 0)
      while (q.size() > abort_at + 1) void'(q.pop_back());
    last = q[q.size() - 1];
    repeat (3) q.push_back({3'b010, last[14:0]});
    start = 1'b1;
    if (wt) begin
      load_en   = 1'b1;
      load_addr = 4'd0;
      load_data = wtd;
    end
    for (int k = 0; k < q.size(); k++) begin
      step();
      start   = 1'b0;
      abort   = 1'b0;
      load_en = 1'b0;
      chk(tag, 32'(obs_v), 32'(q[k]));
      if (k == rst_at) begin
        #2 reset = 1'b0;
        #1 chk({tag, "_async"}, 32'(obs_v), 32'd0);
        break;
      end
      if (k == abort_at) abort = 1'b1;
      if (noise && q[k][17]) begin
        start     = 1'($urandom_range(0, 1));
        load_en   = 1'($urandom_range(0, 1));
        load_addr = (k == 0) ? 4'd2 : 4'($urandom);
        load_data = (k == 0) ? 11'h7ff : 11'($urandom);
      end
    end
    start   = 1'b0;
    abort   = 1'b0;
    load_en = 1'b0;
  endtask

  initial begin
    logic [10:0] prog [7];
    logic [10:0] w;
    prog = '{11'b00000000100, 11'b01000111111, 11'b00000000110,
             11'b01001011111, 11'b00100111111, 11'b11001011111,
             11'b11111111111};
    reset = 1'b0;
    load_en = 1'b0;
    load_addr = '0;
    load_data = '0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) step();
    chk("reset", 32'(obs_v), 32'd0);
    reset = 1'b1;
    repeat (3) begin
      step();
      chk("idle", 32'(obs_v), 32'd0);
    end

    for (int i = 0; i < DEPTH; i++) load(4'(i), 11'h0aa);
    for (int i = 0; i < 7; i++) load(4'(i), prog[i]);
    run("prog", -1, -1, 1'b0, 1'b0, '0);

    for (int i = 0; i < DEPTH; i++) load(4'(i), 11'b00000000001);
    run("nohalt", -1, -1, 1'b0, 1'b0, '0);

    for (int i = 0; i < 7; i++) load(4'(i), prog[i]);
    run("abort", 3 * 5 + 2, -1, 1'b0, 1'b0, '0);
    run("busywr", -1, -1, 1'b1, 1'b0, '0);
    run("restart", -1, -1, 1'b0, 1'b0, '0);
    run("wthru", -1, -1, 1'b0, 1'b1, 11'h123);

    run("rst", 3 * 5 + 1, 3 * 5 + 1, 1'b0, 1'b0, '0);
    step();
    chk("rst_hold", 32'(obs_v), 32'd0);
    reset = 1'b1;
    step();
    chk("rst_idle", 32'(obs_v), 32'd0);
    run("after_rst", -1, -1, 1'b0, 1'b0, '0);

    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        w = 11'($urandom);
        if ($urandom_range(0, 7) != 0 && w[10:8] == 3'b111) w[8] = 1'b0;
        load(4'(i), w);
      end
      run("rand", ($urandom_range(0, 2) == 0) ?
          int'($urandom_range(0, 40)) : -1,
          -1, 1'b1, 1'($urandom_range(0, 1)), 11'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
